// File: rtl/pwr_pkg.sv
// Package: pwr_pkg
// Shared definitions for the toggle-counting delay line.
//   rd_state_t  - counter read handshake states
//   popcount    - number of set bits in a vector of up to POP_MAX_W bits
//   DEF_*       - default geometry for the pipeline and its counters
package pwr_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 4;
  localparam int DEF_CNT_W = 16;
  localparam int POP_MAX_W = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CAP  = 2'd1,
    ACK  = 2'd2
  } rd_state_t;

  // Callers zero-extend narrower vectors to POP_MAX_W bits.
  function automatic int unsigned popcount(input logic [POP_MAX_W-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < POP_MAX_W; i++) begin
      n = n + {31'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/toggle_cnt.sv
// Module: toggle_cnt
// Per-stage switching-activity counter. On every enabled edge the number of
// bits that differ between the stage's current and next value is added to
// the counter. clr zeroes the counter and wins over a same-edge increment.
// Build option: TOGGLE_SAT_EN defined -> counter saturates at all-ones;
//               undefined          -> counter wraps modulo 2^CNT_W.
// Ports:
//   C        in   clock, rising edge
//   R_N      in   asynchronous active-low reset
//   en       in   stage advance enable (counting happens only when set)
//   clr      in   synchronous counter clear
//   old_val  in   WIDTH  current stage register value
//   new_val  in   WIDTH  value the stage loads on this edge
//   cnt      out  CNT_W  accumulated toggle count
module toggle_cnt
  import pwr_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             C,
  input  logic             R_N,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] old_val,
  input  logic [WIDTH-1:0] new_val,
  output logic [CNT_W-1:0] cnt
);

  localparam int SUM_W = CNT_W + 1;

  logic [SUM_W-1:0] inc;
  logic [SUM_W-1:0] sum;
  logic [CNT_W-1:0] cnt_next;

  // The extra sum bit is the carry out of the counter range.
  function automatic logic [CNT_W-1:0] fold(input logic [SUM_W-1:0] s);
`ifdef TOGGLE_SAT_EN
    fold = s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
`else
    fold = s[CNT_W-1:0];
`endif
  endfunction

  always_comb begin
    inc      = SUM_W'(popcount(POP_MAX_W'(old_val ^ new_val)));
    sum      = {1'b0, cnt} + inc;
    cnt_next = fold(sum);
  end

  always_ff @(posedge C or negedge R_N) begin
    if (!R_N) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt_next;
    end
  end

endmodule

// File: rtl/dff_pipe_pwr.sv
// Module: dff_pipe_pwr
// Programmable-depth register delay line with a toggle counter per stage and
// a request/acknowledge port for reading any stage's counter.
// Build option: TOGGLE_SAT_EN selects saturating counters (see toggle_cnt);
//               without it the counters wrap.
// Ports:
//   C          in   clock, rising edge
//   R_N        in   asynchronous active-low reset
//   en         in   shift enable; every stage advances when set
//   valid_in   in   qualifier travelling alongside d
//   d          in   WIDTH  pipeline input
//   q          out  WIDTH  last-stage data
//   valid_out  out  last-stage valid
//   clr        in   synchronous clear of all toggle counters
//   rd_req     in   counter read request, accepted only when idle
//   rd_addr    in   AW     stage index to read
//   rd_ack     out  one-cycle pulse marking rd_data as fresh
//   rd_data    out  CNT_W  captured counter value, held until the next ack
module dff_pipe_pwr
  import pwr_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  parameter  int DEPTH = DEF_DEPTH,
  parameter  int CNT_W = DEF_CNT_W,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             C,
  input  logic             R_N,
  input  logic             en,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             valid_out,
  input  logic             clr,
  input  logic             rd_req,
  input  logic [AW-1:0]    rd_addr,
  output logic             rd_ack,
  output logic [CNT_W-1:0] rd_data
);

  logic [WIDTH-1:0] stg      [DEPTH];
  logic [WIDTH-1:0] stg_next [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [CNT_W-1:0] cnt      [DEPTH];

  rd_state_t        state;
  rd_state_t        state_next;
  logic [AW-1:0]    addr;
  logic [CNT_W-1:0] cap_val;

  always_comb begin
    stg_next[0] = d;
    for (int i = 1; i < DEPTH; i++) begin
      stg_next[i] = stg[i-1];
    end
  end

  // Stage registers and valid chain
  always_ff @(posedge C or negedge R_N) begin
    if (!R_N) begin
      for (int i = 0; i < DEPTH; i++) begin
        stg[i] <= '0;
      end
      vld <= '0;
    end else if (en) begin
      for (int i = 0; i < DEPTH; i++) begin
        stg[i] <= stg_next[i];
      end
      vld <= {vld[DEPTH-2:0], valid_in};
    end
  end

  assign q         = stg[DEPTH-1];
  assign valid_out = vld[DEPTH-1];

  // Per-stage toggle counters
  for (genvar g = 0; g < DEPTH; g++) begin : g_cnt
    toggle_cnt #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
    ) u_cnt (
      .C       (C),
      .R_N     (R_N),
      .en      (en),
      .clr     (clr),
      .old_val (stg[g]),
      .new_val (stg_next[g]),
      .cnt     (cnt[g])
    );
  end

  // An address with no matching stage leaves the default of zero.
  always_comb begin
    cap_val = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (AW'(i) == addr) begin
        cap_val = cnt[i];
      end
    end
  end

  // Read handshake
  always_ff @(posedge C or negedge R_N) begin
    if (!R_N) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    rd_ack     = 1'b0;
    unique case (state)
      IDLE: begin
        if (rd_req) begin
          state_next = CAP;
        end
      end
      CAP: begin
        state_next = ACK;
      end
      ACK: begin
        rd_ack     = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // cap_val reflects the counter registers before this edge's update, so a
  // same-edge increment or clr is not seen by the capture.
  always_ff @(posedge C or negedge R_N) begin
    if (!R_N) begin
      addr    <= '0;
      rd_data <= '0;
    end else begin
      if (state == IDLE && rd_req) begin
        addr <= rd_addr;
      end
      if (state == CAP) begin
        rd_data <= cap_val;
      end
    end
  end

endmodule

// File: tb/tb_dff_pipe_pwr.sv
`timescale 1ns/1ps
module tb_dff_pipe_pwr;

  localparam int WIDTH   = 8;
  localparam int DEPTH   = 4;
  localparam int CNT_W   = 16;
  localparam int AW      = $clog2(DEPTH);
  localparam int CNT_W_S = 4;

  logic             C   = 1'b0;
  logic             R_N = 1'b0;
  logic             en = 1'b0, valid_in = 1'b0, clr = 1'b0, rd_req = 1'b0;
  logic [WIDTH-1:0] d = '0;
  logic [AW-1:0]    rd_addr = '0;
  logic [WIDTH-1:0] q;
  logic             valid_out, rd_ack;
  logic [CNT_W-1:0] rd_data;

  logic               en_s = 1'b0, rd_req_s = 1'b0;
  logic               valid_in_s = 1'b0, clr_s = 1'b0;
  logic [WIDTH-1:0]   d_s = '0;
  logic [AW-1:0]      rd_addr_s = '0;
  logic [WIDTH-1:0]   q_s;
  logic               valid_out_s, rd_ack_s;
  logic [CNT_W_S-1:0] rd_data_s;

  always #5 C = ~C;

  dff_pipe_pwr #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_dut (
    .C(C), .R_N(R_N), .en(en), .valid_in(valid_in), .d(d), .q(q),
    .valid_out(valid_out), .clr(clr), .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_ack(rd_ack), .rd_data(rd_data)
  );

  dff_pipe_pwr #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W_S)) u_small (
    .C(C), .R_N(R_N), .en(en_s), .valid_in(valid_in_s), .d(d_s), .q(q_s),
    .valid_out(valid_out_s), .clr(clr_s), .rd_req(rd_req_s), .rd_addr(rd_addr_s),
    .rd_ack(rd_ack_s), .rd_data(rd_data_s)
  );

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [WIDTH-1:0] dat;
    logic             vl;
  } ent_t;

  typedef struct {
    int unsigned val;
    int unsigned cyc;
  } rd_exp_t;

  ent_t             data_q[$];   // delay line as a FIFO of accepted inputs
  logic [WIDTH-1:0] hist[$];     // enabled inputs, newest last
  int unsigned      cnt_ref[DEPTH];
  rd_exp_t          rd_q[$];
  int               rd_phase;    // 0 idle, 1 capture next, 2 ack next
  int unsigned      rd_addr_lat;
  int unsigned      cyc = 0;
  ent_t             last_exp;
  int               errors = 0;
  int               checks = 0;

  always @(posedge C) cyc <= cyc + 1;

  function automatic int unsigned fold(input int unsigned total, input int w);
    int unsigned lim;
    lim = 32'd1 << w;
`ifdef TOGGLE_SAT_EN
    return (total >= lim) ? lim - 1 : total;
`else
    return total % lim;
`endif
  endfunction

  // Stage i holds the input accepted i enabled edges ago.
  function automatic logic [WIDTH-1:0] stage_val(input int i);
    return hist[hist.size() - 1 - i];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    data_q.delete();
    repeat (DEPTH - 1) data_q.push_back('0);
    hist.delete();
    repeat (DEPTH) hist.push_back('0);
    for (int i = 0; i < DEPTH; i++) cnt_ref[i] = 0;
    rd_q.delete();
    rd_phase = 0;
    rd_addr_lat = 0;
    last_exp = '0;
  endtask

  // ---------------- driver ----------------
  task automatic drive_cycle(input logic e, input logic v, input logic [WIDTH-1:0] dv,
                             input logic c, input logic rq, input logic [AW-1:0] ad);
    logic [WIDTH-1:0] olds[DEPTH];
    @(posedge C); #1;
    if (rd_phase == 1) begin
      rd_exp_t x;
      x.val = (rd_addr_lat < DEPTH) ? cnt_ref[rd_addr_lat] : 0;
      x.cyc = cyc + 1;
      rd_q.push_back(x);
    end
    case (rd_phase)
      0:       if (rq) begin rd_phase = 1; rd_addr_lat = ad; end
      1:       rd_phase = 2;
      default: rd_phase = 0;
    endcase
    en = e; valid_in = v; d = dv; clr = c; rd_req = rq; rd_addr = ad;
    if (e) begin
      ent_t ent;
      ent.dat = dv;
      ent.vl  = v;
      data_q.push_back(ent);
      for (int i = 0; i < DEPTH; i++) olds[i] = stage_val(i);
      hist.push_back(dv);
      if (hist.size() > DEPTH + 1) void'(hist.pop_front());
      for (int i = 0; i < DEPTH; i++)
        cnt_ref[i] = fold(cnt_ref[i] + $countones(olds[i] ^ stage_val(i)), CNT_W);
    end
    if (c) for (int i = 0; i < DEPTH; i++) cnt_ref[i] = 0;
  endtask

  task automatic idle_cycle();
    drive_cycle(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
  endtask

  task automatic rand_cycle(input logic c, input logic rq, input logic [AW-1:0] ad);
    drive_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), WIDTH'($urandom), c, rq, ad);
  endtask

  // rnd selects random shifting during the read; c_cap asserts clr in the capture cycle.
  task automatic do_read(input logic [AW-1:0] ad, input logic c_cap, input logic rnd);
    if (rnd) begin
      rand_cycle(1'b0, 1'b1, ad);
      rand_cycle(c_cap, 1'b0, '0);
      rand_cycle(1'b0, 1'($urandom_range(0, 1)), '0);
    end else begin
      drive_cycle(1'b0, 1'b0, '0, 1'b0, 1'b1, ad);
      drive_cycle(1'b0, 1'b0, '0, c_cap, 1'b0, '0);
      drive_cycle(1'b0, 1'b0, '0, 1'b0, 1'b1, '0);
    end
  endtask

  task automatic do_reset();
    @(posedge C); #1;
    R_N = 1'b0;
    en = 1'b0; valid_in = 1'b0; d = '0; clr = 1'b0; rd_req = 1'b0; rd_addr = '0;
    en_s = 1'b0; d_s = '0; rd_req_s = 1'b0;
    model_reset();
    #1;
    check("reset_q", q, 0);
    check("reset_valid_out", valid_out, 0);
    check("reset_rd_ack", rd_ack, 0);
    check("reset_rd_data", rd_data, 0);
    repeat (2) @(posedge C);
    #1 R_N = 1'b1;
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic    e_e, rn_e;
    rd_exp_t rx;
    forever begin
      @(posedge C);
      e_e  = en;
      rn_e = R_N;
      @(negedge C);
      if (rn_e && R_N) begin
        if (e_e) begin
          if (data_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL data_scoreboard: queue empty on enabled edge (cycle %0d)", cyc);
          end else begin
            last_exp = data_q.pop_front();
          end
        end
        check("q", q, last_exp.dat);
        check("valid_out", valid_out, last_exp.vl);
        if (rd_ack) begin
          if (rd_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL rd_ack: got unexpected ack expected none (cycle %0d)", cyc);
          end else begin
            rx = rd_q.pop_front();
            check("rd_data", rd_data, rx.val);
            check("rd_ack_cycle", cyc, rx.cyc);
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int unsigned tog;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] seq[3];
    bit got;

    model_reset();
    do_reset();

    // Single FF byte then zeros: appears at q after DEPTH enabled edges.
    drive_cycle(1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, '0);
    repeat (6) drive_cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, '0);

    // Alternating full-byte toggles, then read stage 0.
    do_reset();
    for (int i = 0; i < 10; i++)
      drive_cycle(1'b1, 1'b1, (i % 2 == 0) ? 8'hFF : 8'h00, 1'b0, 1'b0, '0);
    do_read('0, 1'b0, 1'b0);
    repeat (2) idle_cycle();

    // en=0 with toggling d: nothing moves, counts unchanged.
    for (int i = 0; i < 6; i++)
      drive_cycle(1'b0, 1'b1, WIDTH'($urandom), 1'b0, 1'b0, '0);
    for (int a = 0; a < DEPTH; a++) do_read(AW'(a), 1'b0, 1'b0);

    // clr on the same edge as a toggle, then clr in the capture cycle.
    drive_cycle(1'b1, 1'b1, 8'h5A, 1'b1, 1'b0, '0);
    do_read('0, 1'b0, 1'b0);
    repeat (5) drive_cycle(1'b1, 1'b1, WIDTH'($urandom), 1'b0, 1'b0, '0);
    do_read('0, 1'b1, 1'b0);
    do_read('0, 1'b0, 1'b0);

    // Reset while the read is capturing.
    repeat (5) drive_cycle(1'b1, 1'b1, WIDTH'($urandom), 1'b0, 1'b0, '0);
    do_read(AW'(1), 1'b0, 1'b0);
    drive_cycle(1'b0, 1'b0, '0, 1'b0, 1'b1, AW'(1));
    do_reset();
    repeat (4) idle_cycle();
    repeat (3) drive_cycle(1'b1, 1'b1, WIDTH'($urandom), 1'b0, 1'b0, '0);
    do_read(AW'(1), 1'b0, 1'b0);

    // Randomised traffic with interleaved reads and occasional clears.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 7) == 0)
        do_read(AW'($urandom_range(0, DEPTH - 1)), 1'($urandom_range(0, 3) == 0), 1'b1);
      else
        rand_cycle(1'($urandom_range(0, 29) == 0), 1'b0, '0);
    end
    repeat (4) idle_cycle();
    check("rd_pending_at_end", rd_q.size(), 0);

    // Narrow counter: three full-byte toggles at stage 0 of a CNT_W=4 instance.
    do_reset();
    seq[0] = 8'hFF; seq[1] = 8'h00; seq[2] = 8'hFF;
    tog  = 0;
    prev = '0;
    for (int i = 0; i < 3; i++) begin
      @(posedge C); #1;
      en_s = 1'b1; d_s = seq[i];
      tog  = tog + $countones(prev ^ seq[i]);
      prev = seq[i];
    end
    @(posedge C); #1;
    en_s = 1'b0; rd_req_s = 1'b1; rd_addr_s = '0;
    @(posedge C); #1;
    rd_req_s = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 6 && !got; i++) begin
      @(negedge C);
      if (rd_ack_s) begin
        got = 1'b1;
        check("narrow_cnt_rd_data", rd_data_s, fold(tog, CNT_W_S));
      end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL narrow_cnt_ack: got no ack expected ack within 6 cycles");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
